// File: rtl/thread_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// thread_scheduler_pkg
//   Shared constants, types and a small helper for the barrel-pipeline thread
//   scheduler and its round-robin arbiter.
//   Contents:
//     N_THREADS_DEF   default hardware thread count
//     TID_W_DEF       thread id width for the default thread count
//     RESET_PC_DEF    PC loaded into every thread on reset
//     EXC_VECTOR_DEF  PC loaded on an exception redirect
//     threadid_t      thread id type (default width)
//     vptr_t          one-bit-per-thread vector type (default width)
//     wrap_inc()      increment modulo n
// -----------------------------------------------------------------------------
package thread_scheduler_pkg;

  localparam int unsigned N_THREADS_DEF  = 8;
  localparam int unsigned TID_W_DEF      = $clog2(N_THREADS_DEF);
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_1000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_2000;

  typedef logic [TID_W_DEF-1:0]     threadid_t;
  typedef logic [N_THREADS_DEF-1:0] vptr_t;

  // Next index after v in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Searches req_i starting at ptr_i
//   and wrapping modulo N; the first requester found is granted. Kept generic
//   so it can be reused for other N-way arbitration points.
//   Ports:
//     req_i        N    request vector (bit i = requester i)
//     ptr_i        IW   search start index (must be < N)
//     gnt_valid_o  1    at least one requester is active
//     gnt_id_o     IW   granted requester (0 when gnt_valid_o is low)
// -----------------------------------------------------------------------------
module rr_arbiter
  import thread_scheduler_pkg::*;
#(
  parameter  int unsigned N  = N_THREADS_DEF,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_id_o
);

  int unsigned idx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 32'(ptr_i);
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_valid_o && req_i[IW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IW'(idx);
      end
      idx = wrap_inc(idx, N);
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
//   Per-thread PC owner and fetch scheduler for the N-thread barrel pipeline.
//   Every cycle one ready (not stalled) thread is offered to stage_if in
//   round-robin order. WB redirects and exceptions rewrite thread PCs and
//   trigger a one-cycle registered flush of the affected thread. Cache/TLB
//   misses stall a thread until its fill returns.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     if_ready_i             stage_if accepts the offered fetch
//     fetch_valid_o          a thread is offered for fetch
//     fetch_thread_o         offered thread id
//     fetch_pc_o             PC of the offered thread
//     stall_set_en_i/_thread_i  miss reported for a thread
//     wake_en_i/wake_thread_i   fill returned, thread may resume
//     wb_pc_en_i             one-hot redirect from stage_wb
//     wb_pc_data_i           redirect target
//     exc_en_i/exc_thread_i  exception raised by stage_wb
//     flush_en_o/flush_thread_o  registered squash request
//     pc_o                   all thread PCs, thread 0 in the LSBs
//     stalled_o              stall vector (bit i = thread i)
// -----------------------------------------------------------------------------
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter  int unsigned N_THREADS  = N_THREADS_DEF,
  parameter  logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter  logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  localparam int unsigned TID_W      = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      if_ready_i,
  output logic                      fetch_valid_o,
  output logic [TID_W-1:0]          fetch_thread_o,
  output logic [31:0]               fetch_pc_o,

  input  logic                      stall_set_en_i,
  input  logic [TID_W-1:0]          stall_set_thread_i,
  input  logic                      wake_en_i,
  input  logic [TID_W-1:0]          wake_thread_i,

  input  logic [N_THREADS-1:0]      wb_pc_en_i,
  input  logic [31:0]               wb_pc_data_i,
  input  logic                      exc_en_i,
  input  logic [TID_W-1:0]          exc_thread_i,

  output logic                      flush_en_o,
  output logic [TID_W-1:0]          flush_thread_o,
  output logic [N_THREADS*32-1:0]   pc_o,
  output logic [N_THREADS-1:0]      stalled_o
);

  logic [31:0]          pc_q [N_THREADS];
  logic [31:0]          pc_d [N_THREADS];
  logic [N_THREADS-1:0] stalled_q, stalled_d;
  logic [TID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 flush_en_q, flush_en_d;
  logic [TID_W-1:0]     flush_thread_q, flush_thread_d;

  logic [N_THREADS-1:0] ready;
  logic                 gnt_valid;
  logic [TID_W-1:0]     gnt_id;
  logic                 accept;

  // ---------------------------------------------------------------------------
  // Selection: purely from registered state, so the offer is stable all cycle.
  // ---------------------------------------------------------------------------
  assign ready = ~stalled_q;

  rr_arbiter #(
    .N (N_THREADS)
  ) u_rr_arbiter (
    .req_i       (ready),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Registers may still hold pre-reset garbage while rst is asserted, so the
  // offer is masked rather than trusting the stall vector.
  assign fetch_valid_o  = gnt_valid & ~rst;
  assign fetch_thread_o = gnt_id;
  assign fetch_pc_o     = pc_q[gnt_id];
  assign accept         = fetch_valid_o & if_ready_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = TID_W'(wrap_inc(32'(gnt_id), N_THREADS));
    end

    for (int unsigned i = 0; i < N_THREADS; i++) begin
      pc_d[i]      = pc_q[i];
      stalled_d[i] = stalled_q[i];

      // Exception beats a WB redirect, which beats the sequential +4.
      if (exc_en_i && (exc_thread_i == TID_W'(i))) begin
        pc_d[i] = EXC_VECTOR;
      end else if (wb_pc_en_i[i]) begin
        pc_d[i] = wb_pc_data_i;
      end else if (accept && (gnt_id == TID_W'(i))) begin
        pc_d[i] = pc_q[i] + 32'd4;
      end

      // An exception restarts the thread at the vector, so any outstanding
      // miss is moot. A new miss beats a same-cycle wake: the wake belongs to
      // the older miss.
      if (exc_en_i && (exc_thread_i == TID_W'(i))) begin
        stalled_d[i] = 1'b0;
      end else if (stall_set_en_i && (stall_set_thread_i == TID_W'(i))) begin
        stalled_d[i] = 1'b1;
      end else if (wake_en_i && (wake_thread_i == TID_W'(i))) begin
        stalled_d[i] = 1'b0;
      end
    end
  end

  // Flush target: the excepting thread, else the redirected one. The
  // descending scan leaves the lowest set bit should the one-hot contract
  // ever be broken.
  always_comb begin
    flush_en_d     = 1'b0;
    flush_thread_d = flush_thread_q;
    if (exc_en_i) begin
      flush_en_d     = 1'b1;
      flush_thread_d = exc_thread_i;
    end else if (|wb_pc_en_i) begin
      flush_en_d = 1'b1;
      for (int i = N_THREADS - 1; i >= 0; i--) begin
        if (wb_pc_en_i[i]) begin
          flush_thread_d = TID_W'(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        pc_q[i] <= RESET_PC;
      end
      stalled_q      <= '0;
      rr_ptr_q       <= '0;
      flush_en_q     <= 1'b0;
      flush_thread_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_THREADS; i++) begin
        pc_q[i] <= pc_d[i];
      end
      stalled_q      <= stalled_d;
      rr_ptr_q       <= rr_ptr_d;
      flush_en_q     <= flush_en_d;
      flush_thread_q <= flush_thread_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_THREADS; g++) begin : g_pc_out
    assign pc_o[g*32 +: 32] = pc_q[g];
  end

  assign stalled_o      = stalled_q;
  assign flush_en_o     = flush_en_q;
  assign flush_thread_o = flush_thread_q;

  // stage_wb redirects at most one thread per cycle.
  a_wb_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(wb_pc_en_i));

endmodule

// File: tb/tb_thread_scheduler.sv
module tb_thread_scheduler;
  import thread_scheduler_pkg::*;

  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready_i;
  logic        fetch_valid_o;
  threadid_t   fetch_thread_o;
  logic [31:0] fetch_pc_o;
  logic        stall_set_en_i;
  threadid_t   stall_set_thread_i;
  logic        wake_en_i;
  threadid_t   wake_thread_i;
  vptr_t       wb_pc_en_i;
  logic [31:0] wb_pc_data_i;
  logic        exc_en_i;
  threadid_t   exc_thread_i;
  logic        flush_en_o;
  threadid_t   flush_thread_o;
  logic [NT*32-1:0] pc_o;
  vptr_t       stalled_o;

  always #5 clk = ~clk;

  thread_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .if_ready_i         (if_ready_i),
    .fetch_valid_o      (fetch_valid_o),
    .fetch_thread_o     (fetch_thread_o),
    .fetch_pc_o         (fetch_pc_o),
    .stall_set_en_i     (stall_set_en_i),
    .stall_set_thread_i (stall_set_thread_i),
    .wake_en_i          (wake_en_i),
    .wake_thread_i      (wake_thread_i),
    .wb_pc_en_i         (wb_pc_en_i),
    .wb_pc_data_i       (wb_pc_data_i),
    .exc_en_i           (exc_en_i),
    .exc_thread_i       (exc_thread_i),
    .flush_en_o         (flush_en_o),
    .flush_thread_o     (flush_thread_o),
    .pc_o               (pc_o),
    .stalled_o          (stalled_o)
  );

  // Reference model state
  logic [31:0] m_pc [NT];
  vptr_t       m_stall = '0;
  int          m_ptr   = 0;
  logic        m_fe    = 1'b0;
  threadid_t   m_ft    = '0;

  typedef struct packed {
    logic [NT*32-1:0] pcv;
    vptr_t            stl;
    logic             fe;
    threadid_t        ft;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic      obs_val;
  threadid_t obs_thr;
  logic [31:0] snap [NT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mdl_sel();
    for (int k = 0; k < NT; k++) begin
      int t;
      t = (m_ptr + k) % NT;
      if (!m_stall[t]) return t;
    end
    return -1;
  endfunction

  task automatic clr_in();
    if_ready_i         = 1'b0;
    stall_set_en_i     = 1'b0;
    stall_set_thread_i = '0;
    wake_en_i          = 1'b0;
    wake_thread_i      = '0;
    wb_pc_en_i         = '0;
    wb_pc_data_i       = '0;
    exc_en_i           = 1'b0;
    exc_thread_i       = '0;
  endtask

  // One clock: check the combinational offer, push the model's expected
  // post-edge state, then pop and compare it after the edge.
  task automatic cycle();
    int   sel;
    logic acc;
    logic exp_val;
    exp_t e;
    @(negedge clk);
    sel     = mdl_sel();
    exp_val = (sel >= 0) && !rst;
    obs_val = fetch_valid_o;
    obs_thr = fetch_thread_o;
    chk("fetch_valid", 32'(fetch_valid_o), 32'(exp_val));
    if (exp_val) begin
      chk("fetch_thread", 32'(fetch_thread_o), 32'(sel));
      chk("fetch_pc", fetch_pc_o, m_pc[sel]);
    end
    acc = exp_val && if_ready_i;
    if (rst) begin
      for (int i = 0; i < NT; i++) m_pc[i] = RESET_PC_DEF;
      m_stall = '0;
      m_ptr   = 0;
      m_fe    = 1'b0;
      m_ft    = '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (exc_en_i && int'(exc_thread_i) == i) begin
          m_pc[i]    = EXC_VECTOR_DEF;
          m_stall[i] = 1'b0;
        end else begin
          if (wb_pc_en_i[i])          m_pc[i] = wb_pc_data_i;
          else if (acc && sel == i)   m_pc[i] = m_pc[i] + 32'd4;
          if (stall_set_en_i && int'(stall_set_thread_i) == i) m_stall[i] = 1'b1;
          else if (wake_en_i && int'(wake_thread_i) == i)      m_stall[i] = 1'b0;
        end
      end
      if (acc) m_ptr = (sel + 1) % NT;
      if (exc_en_i) begin
        m_fe = 1'b1;
        m_ft = exc_thread_i;
      end else if (wb_pc_en_i != '0) begin
        m_fe = 1'b1;
        for (int i = NT - 1; i >= 0; i--) if (wb_pc_en_i[i]) m_ft = threadid_t'(i);
      end else begin
        m_fe = 1'b0;
      end
    end
    for (int i = 0; i < NT; i++) e.pcv[i*32 +: 32] = m_pc[i];
    e.stl = m_stall;
    e.fe  = m_fe;
    e.ft  = m_ft;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < NT; i++)
      chk($sformatf("pc[%0d]", i), pc_o[i*32 +: 32], e.pcv[i*32 +: 32]);
    chk("stalled", 32'(stalled_o), 32'(e.stl));
    chk("flush_en", 32'(flush_en_o), 32'(e.fe));
    if (e.fe) chk("flush_thread", 32'(flush_thread_o), 32'(e.ft));
  endtask

  initial begin
    int guard;
    clr_in();
    rst = 1'b1;

    // Reset
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NT; i++) chk("reset_pc", pc_o[i*32 +: 32], 32'h1000);
    chk("reset_stalled", 32'(stalled_o), 32'h0);
    chk("reset_flush", 32'(flush_en_o), 32'h0);
    chk("reset_flush_thr", 32'(flush_thread_o), 32'h0);

    // Free-running round robin
    for (int k = 0; k < 16; k++) begin
      if_ready_i = 1'b1;
      cycle();
      chk("rr_valid", 32'(obs_val), 32'h1);
      chk("rr_seq", 32'(obs_thr), 32'(k % 8));
    end
    for (int i = 0; i < NT; i++) chk("rr_pc_end", pc_o[i*32 +: 32], 32'h1008);

    // Stall thread 2 at cycle 3, wake at cycle 10
    for (int k = 0; k < 18; k++) begin
      if_ready_i         = 1'b1;
      stall_set_en_i     = (k == 3);
      stall_set_thread_i = 3'd2;
      wake_en_i          = (k == 10);
      wake_thread_i      = 3'd2;
      cycle();
      if (k >= 4 && k <= 10) begin
        chk("skip2", 32'(obs_thr == 3'd2), 32'h0);
        chk("pc2_hold", pc_o[2*32 +: 32], 32'h100C);
      end
      if (k == 17) chk("resume2", 32'(obs_thr), 32'h2);
    end
    clr_in();

    // WB redirect in the cycle thread 4 is accepted
    guard = 0;
    if_ready_i = 1'b1;
    while (mdl_sel() != 4 && guard < 16) begin
      cycle();
      guard++;
    end
    chk("reach_thread4", 32'(guard < 16), 32'h1);
    wb_pc_en_i   = 8'b0001_0000;
    wb_pc_data_i = 32'h4000;
    cycle();
    clr_in();
    chk("redir_accepted", 32'(obs_thr), 32'h4);
    chk("redir_pc4", pc_o[4*32 +: 32], 32'h4000);
    chk("redir_flush_en", 32'(flush_en_o), 32'h1);
    chk("redir_flush_thr", 32'(flush_thread_o), 32'h4);
    cycle();
    chk("redir_flush_drop", 32'(flush_en_o), 32'h0);

    // Exception beats redirect and clears the stall
    stall_set_en_i     = 1'b1;
    stall_set_thread_i = 3'd5;
    cycle();
    clr_in();
    chk("exc_pre_stall", 32'(stalled_o[5]), 32'h1);
    exc_en_i     = 1'b1;
    exc_thread_i = 3'd5;
    wb_pc_en_i   = 8'b0010_0000;
    wb_pc_data_i = 32'h4000;
    cycle();
    clr_in();
    chk("exc_pc5", pc_o[5*32 +: 32], 32'h2000);
    chk("exc_unstall5", 32'(stalled_o[5]), 32'h0);
    chk("exc_flush_en", 32'(flush_en_o), 32'h1);
    chk("exc_flush_thr", 32'(flush_thread_o), 32'h5);

    // All threads stalled
    for (int t = 0; t < NT; t++) begin
      stall_set_en_i     = 1'b1;
      stall_set_thread_i = threadid_t'(t);
      cycle();
    end
    clr_in();
    chk("all_stalled", 32'(stalled_o), 32'hFF);
    for (int i = 0; i < NT; i++) snap[i] = m_pc[i];
    for (int k = 0; k < 3; k++) begin
      if_ready_i = 1'b1;
      cycle();
      chk("none_valid", 32'(obs_val), 32'h0);
    end
    for (int i = 0; i < NT; i++) chk("frozen_pc", pc_o[i*32 +: 32], snap[i]);
    wake_en_i     = 1'b1;
    wake_thread_i = 3'd6;
    cycle();
    wake_en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("only6_valid", 32'(obs_val), 32'h1);
      chk("only6_thr", 32'(obs_thr), 32'h6);
    end
    chk("pc6_adv", pc_o[6*32 +: 32], snap[6] + 32'd16);
    if_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chk("pc6_hold", pc_o[6*32 +: 32], snap[6] + 32'd16);
    wake_en_i     = 1'b1;
    wake_thread_i = 3'd0;
    cycle();
    wake_en_i  = 1'b0;
    if_ready_i = 1'b1;
    cycle();
    chk("ptr_held", 32'(obs_thr), 32'h0);
    clr_in();

    // Same-cycle stall_set and wake on thread 1
    wake_en_i     = 1'b1;
    wake_thread_i = 3'd1;
    cycle();
    chk("wake1", 32'(stalled_o[1]), 32'h0);
    stall_set_en_i     = 1'b1;
    stall_set_thread_i = 3'd1;
    cycle();
    clr_in();
    chk("set_beats_wake", 32'(stalled_o[1]), 32'h1);

    // Random traffic with a reset pulse in the middle
    for (int r = 0; r < 150; r++) begin
      if_ready_i         = ($urandom_range(0, 3) != 0);
      stall_set_en_i     = ($urandom_range(0, 3) == 0);
      stall_set_thread_i = threadid_t'($urandom_range(0, 7));
      wake_en_i          = ($urandom_range(0, 1) == 0);
      wake_thread_i      = threadid_t'($urandom_range(0, 7));
      wb_pc_en_i         = '0;
      if ($urandom_range(0, 4) == 0) wb_pc_en_i[$urandom_range(0, 7)] = 1'b1;
      wb_pc_data_i       = $urandom() & 32'hFFFF_FFFC;
      exc_en_i           = ($urandom_range(0, 9) == 0);
      exc_thread_i       = threadid_t'($urandom_range(0, 7));
      rst                = (r == 75);
      cycle();
      if (r == 75) begin
        for (int i = 0; i < NT; i++) chk("midrst_pc", pc_o[i*32 +: 32], 32'h1000);
        chk("midrst_stalled", 32'(stalled_o), 32'h0);
        chk("midrst_flush", 32'(flush_en_o), 32'h0);
      end
    end
    rst = 1'b0;
    clr_in();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
